// File: rtl/io_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of an IO-register file: one access per three cycles,
// DMA-first with a starvation counter that lets a waiting CPU through.
module io_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk_mem,
    input  logic        i_rst,
    input  logic        i_cpu_req,
    input  logic [23:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic        i_cpu_write,
    input  logic [1:0]  i_cpu_width,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ack,
    input  logic        i_dma_req,
    input  logic [23:0] i_dma_addr,
    input  logic [31:0] i_dma_wdata,
    input  logic        i_dma_write,
    input  logic [1:0]  i_dma_width,
    input  logic        i_dma_lock,
    output logic [31:0] o_dma_rdata,
    output logic        o_dma_ack,
    output logic [23:0] o_io_addr,
    output logic [31:0] o_io_data_in,
    input  logic [31:0] i_io_data_out,
    output logic        o_io_read,
    output logic        o_io_write,
    output logic [1:0]  o_io_width
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_starve_cnt;
    logic          r_winner_dma;
    logic [23:0]   r_io_addr;
    logic [31:0]   r_io_data_in;
    logic [1:0]    r_io_width;
    logic          r_io_read;
    logic          r_io_write;
    logic [31:0]   r_cpu_rdata;
    logic [31:0]   r_dma_rdata;
    logic          r_cpu_ack;
    logic          r_dma_ack;

    logic w_dma_win;
    logic w_cpu_win;

    // A locked DMA always wins; otherwise the CPU wins only once the starve counter saturates.
    always_comb begin
        w_dma_win = i_dma_req && (i_dma_lock || !i_cpu_req || (r_starve_cnt != LIM));
        w_cpu_win = i_cpu_req && !w_dma_win;
    end

    always_ff @(posedge i_clk_mem or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_winner_dma <= 1'b0;
            r_io_addr    <= '0;
            r_io_data_in <= '0;
            r_io_width   <= '0;
            r_io_read    <= 1'b0;
            r_io_write   <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!i_cpu_req || w_cpu_win) begin
                        r_starve_cnt <= '0;
                    end else if (w_dma_win && (r_starve_cnt != LIM)) begin
                        r_starve_cnt <= r_starve_cnt + CW'(1);
                    end
                    if (w_dma_win || w_cpu_win) begin
                        r_winner_dma <= w_dma_win;
                        r_io_addr    <= w_dma_win ? i_dma_addr  : i_cpu_addr;
                        r_io_data_in <= w_dma_win ? i_dma_wdata : i_cpu_wdata;
                        r_io_width   <= w_dma_win ? i_dma_width : i_cpu_width;
                        r_io_write   <= w_dma_win ? i_dma_write : i_cpu_write;
                        r_io_read    <= w_dma_win ? !i_dma_write : !i_cpu_write;
                        r_state      <= ACC;
                    end
                end
                ACC: begin
                    // The register file commits/reads at this edge; rdata is the pre-write word.
                    r_io_read  <= 1'b0;
                    r_io_write <= 1'b0;
                    if (r_winner_dma) begin
                        r_dma_rdata <= i_io_data_out;
                        r_dma_ack   <= 1'b1;
                    end else begin
                        r_cpu_rdata <= i_io_data_out;
                        r_cpu_ack   <= 1'b1;
                    end
                    r_state <= ACK;
                end
                ACK: begin
                    r_cpu_ack <= 1'b0;
                    r_dma_ack <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_cpu_ack    = r_cpu_ack;
    assign o_dma_rdata  = r_dma_rdata;
    assign o_dma_ack    = r_dma_ack;
    assign o_io_addr    = r_io_addr;
    assign o_io_data_in = r_io_data_in;
    assign o_io_width   = r_io_width;
    assign o_io_read    = r_io_read;
    assign o_io_write   = r_io_write;

endmodule

// File: tb/tb_io_arbiter.sv
// Directed bench for io_arbiter: models the IO-register file and checks each port's
// read data through per-port expectation queues, plus grant ordering and reset behaviour.
module tb_io_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_write, dma_req, dma_write, dma_lock;
    logic [23:0] cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic [1:0]  cpu_width, dma_width;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic [23:0] io_addr;
    logic [31:0] io_data_in, io_data_out;
    logic        io_read, io_write;
    logic [1:0]  io_width;

    io_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk_mem(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .i_cpu_write(cpu_write), .i_cpu_width(cpu_width),
        .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
        .i_dma_req(dma_req), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .i_dma_write(dma_write), .i_dma_width(dma_width), .i_dma_lock(dma_lock),
        .o_dma_rdata(dma_rdata), .o_dma_ack(dma_ack),
        .o_io_addr(io_addr), .o_io_data_in(io_data_in), .i_io_data_out(io_data_out),
        .o_io_read(io_read), .o_io_write(io_write), .o_io_width(io_width)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cpu_acks = 0, dma_acks = 0;
    int cpu_ack_cyc = -1, dma_ack_cyc = -1;
    logic [31:0] cpu_q[$];
    logic [31:0] dma_q[$];

    // IO-register file model: 64 words, combinational read, byte/half/word write merge.
    logic [31:0] mem [0:63];
    logic        mem_init;
    assign io_data_out = mem[io_addr[7:2]];

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00000111;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] w, input logic [1:0] a);
        logic [31:0] m;
        if (w == 2'b00) begin
            m = 32'hFF << (8 * a);
            return (old & ~m) | ((d & 32'hFF) << (8 * a));
        end else if (w == 2'b01) begin
            m = 32'hFFFF << (16 * a[1]);
            return (old & ~m) | ((d & 32'hFFFF) << (16 * a[1]));
        end
        return d;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (io_write) begin
            mem[io_addr[7:2]] <= merge(mem[io_addr[7:2]], io_data_in, io_width, io_addr[1:0]);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic flag(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed event expected none", tag);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_exclusive", {31'b0, cpu_ack & dma_ack}, 32'h0);
            chk("strobe_exclusive", {31'b0, io_read & io_write}, 32'h0);
        end
        if (cpu_ack === 1'b1) begin
            cpu_acks++;
            cpu_ack_cyc = cyc;
            if (cpu_q.size() == 0) flag("cpu_unexpected_ack");
            else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (dma_ack === 1'b1) begin
            dma_acks++;
            dma_ack_cyc = cyc;
            if (dma_q.size() == 0) flag("dma_unexpected_ack");
            else chk("dma_rdata", dma_rdata, dma_q.pop_front());
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_go(input logic [23:0] a, input logic [31:0] d, input logic w, input logic [1:0] wd);
        cpu_addr = a; cpu_wdata = d; cpu_write = w; cpu_width = wd; cpu_req = 1'b1;
    endtask

    task automatic dma_go(input logic [23:0] a, input logic [31:0] d, input logic w, input logic [1:0] wd);
        dma_addr = a; dma_wdata = d; dma_write = w; dma_width = wd; dma_req = 1'b1;
    endtask

    task automatic cpu_txn(input logic [23:0] a, input logic [31:0] d, input logic w,
                           input logic [1:0] wd, input logic [31:0] exp_rd, input string tag);
        int base;
        step();
        base = cpu_acks;
        cpu_q.push_back(exp_rd);
        cpu_go(a, d, w, wd);
        for (int k = 0; k < 20 && cpu_acks == base; k++) step();
        cpu_req = 1'b0;
        chk(tag, 32'(cpu_acks - base), 32'd1);
    endtask

    logic [31:0] exp_mem [0:63];
    int t0, base_c, base_d, last_d;
    logic [31:0] pre;

    initial begin
        for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
        rst = 1'b1; mem_init = 1'b1; dma_lock = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_write = 1'b0; cpu_width = '0;
        dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_write = 1'b0; dma_width = '0;
        step(); step();
        chk("rst_io_read", {31'b0, io_read}, 32'h0);
        chk("rst_io_write", {31'b0, io_write}, 32'h0);
        chk("rst_cpu_ack", {31'b0, cpu_ack}, 32'h0);
        chk("rst_dma_ack", {31'b0, dma_ack}, 32'h0);
        chk("rst_io_addr", {8'b0, io_addr}, 32'h0);
        chk("rst_io_data_in", io_data_in, 32'h0);
        chk("rst_io_width", {30'b0, io_width}, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        mem_init = 1'b0;
        rst = 1'b0;

        // CPU word read alone.
        step();
        t0 = cyc;
        cpu_q.push_back(exp_mem[0]);
        cpu_go(24'h000100, 32'h0, 1'b0, 2'b10);
        step();
        chk("rd_io_read", {31'b0, io_read}, 32'h1);
        chk("rd_io_write", {31'b0, io_write}, 32'h0);
        chk("rd_io_addr", {8'b0, io_addr}, 32'h100);
        chk("rd_io_width", {30'b0, io_width}, 32'h2);
        step();
        chk("rd_cpu_ack", {31'b0, cpu_ack}, 32'h1);
        chk("rd_ack_cycle", 32'(cpu_ack_cyc - t0), 32'd2);
        cpu_req = 1'b0;
        step();
        chk("rd_ack_pulse", {31'b0, cpu_ack}, 32'h0);
        chk("rd_strobe_off", {31'b0, io_read}, 32'h0);
        chk("rd_rdata_hold", cpu_rdata, exp_mem[0]);

        // CPU byte write 0xAB to 0x105, then read the word back.
        step();
        cpu_q.push_back(exp_mem[1]);
        exp_mem[1] = (exp_mem[1] & 32'hFFFF00FF) | 32'h0000AB00;
        cpu_go(24'h000105, 32'h000000AB, 1'b1, 2'b00);
        step();
        chk("wr_io_write", {31'b0, io_write}, 32'h1);
        chk("wr_io_read", {31'b0, io_read}, 32'h0);
        chk("wr_io_data_in", io_data_in, 32'h000000AB);
        chk("wr_io_width", {30'b0, io_width}, 32'h0);
        chk("wr_io_addr", {8'b0, io_addr}, 32'h105);
        step();
        chk("wr_cpu_ack", {31'b0, cpu_ack}, 32'h1);
        chk("wr_strobe_off", {31'b0, io_write}, 32'h0);
        cpu_req = 1'b0;
        chk("wr_mem", mem[1], exp_mem[1]);
        cpu_txn(24'h000104, 32'h0, 1'b0, 2'b10, exp_mem[1], "wr_readback_done");

        // Simultaneous requests: DMA first, CPU next.
        step();
        t0 = cyc; base_c = cpu_acks; base_d = dma_acks;
        cpu_q.push_back(exp_mem[4]);
        dma_q.push_back(exp_mem[8]);
        cpu_go(24'h000110, 32'h0, 1'b0, 2'b10);
        dma_go(24'h000120, 32'h0, 1'b0, 2'b10);
        for (int k = 0; k < 30 && cpu_acks == base_c; k++) begin
            step();
            if (dma_ack) dma_req = 1'b0;
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("both_dma_count", 32'(dma_acks - base_d), 32'd1);
        chk("both_dma_cycle", 32'(dma_ack_cyc - t0), 32'd2);
        chk("both_cpu_cycle", 32'(cpu_ack_cyc - t0), 32'd5);

        // Starvation: four DMA grants, then the CPU.
        step();
        t0 = cyc; base_c = cpu_acks; base_d = dma_acks;
        cpu_q.push_back(exp_mem[12]);
        for (int k = 0; k < 4; k++) dma_q.push_back(exp_mem[16]);
        cpu_go(24'h000130, 32'h0, 1'b0, 2'b10);
        dma_go(24'h000140, 32'h0, 1'b0, 2'b10);
        for (int k = 0; k < 40 && cpu_acks == base_c; k++) step();
        cpu_req = 1'b0; dma_req = 1'b0;
        chk("starve_dma_count", 32'(dma_acks - base_d), 32'd4);
        chk("starve_cpu_cycle", 32'(cpu_ack_cyc - t0), 32'd14);
        chk("starve_cnt_clear", 32'(dut.r_starve_cnt), 32'd0);

        // Lock: six DMA grants with the CPU shut out, CPU wins once the lock drops.
        step();
        dma_lock = 1'b1; base_c = cpu_acks; base_d = dma_acks; last_d = -100;
        cpu_q.push_back(exp_mem[13]);
        for (int k = 0; k < 6; k++) dma_q.push_back(exp_mem[17]);
        cpu_go(24'h000134, 32'h0, 1'b0, 2'b10);
        dma_go(24'h000144, 32'h0, 1'b0, 2'b10);
        for (int k = 0; k < 60 && cpu_acks == base_c; k++) begin
            step();
            if (dma_ack && (dma_acks - base_d) == 6) begin
                dma_lock = 1'b0;
                last_d = cyc;
                chk("lock_starve_sat", 32'(dut.r_starve_cnt), 32'd4);
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        chk("lock_dma_count", 32'(dma_acks - base_d), 32'd6);
        chk("lock_cpu_cycle", 32'(cpu_ack_cyc - last_d), 32'd3);

        // Reset in the ACC cycle of a write: no commit, no ack, request served afterwards.
        step();
        pre = exp_mem[2];
        base_c = cpu_acks;
        cpu_q.push_back(pre);
        cpu_go(24'h000108, 32'h12345678, 1'b1, 2'b10);
        step();
        chk("rstacc_io_write_before", {31'b0, io_write}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rstacc_io_write_async", {31'b0, io_write}, 32'h0);
        chk("rstacc_cpu_ack", {31'b0, cpu_ack}, 32'h0);
        step();
        chk("rstacc_mem_kept", mem[2], pre);
        chk("rstacc_no_ack", 32'(cpu_acks - base_c), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 20 && cpu_acks == base_c; k++) step();
        cpu_req = 1'b0;
        chk("rstacc_reserved", 32'(cpu_acks - base_c), 32'd1);
        step();
        chk("rstacc_mem_written", mem[2], 32'h12345678);

        step(); step();
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("dma_q_drained", 32'(dma_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive DMA grants tolerated while CPU waits.
REQ-002 clk_mem  input  1  memory-domain clock; all state on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req  input  1  CPU requests one IO-register access; held high until cpu_ack.
REQ-005 cpu_addr  input  24  CPU byte address.
REQ-006 cpu_wdata  input  32  CPU write data, right-aligned.
REQ-007 cpu_write  input  1  1 = write, 0 = read.
REQ-008 cpu_width  input  2  00 byte, 01 halfword, 1x word.
REQ-009 cpu_rdata  output  32  read data, valid while cpu_ack high.
REQ-010 cpu_ack  output  1  one-cycle completion pulse.
REQ-011 dma_req, dma_addr, dma_wdata, dma_write, dma_width, dma_rdata, dma_ack: same widths and meaning as the CPU set, for the DMA port.
REQ-012 dma_lock  input  1  DMA holds the resource for back-to-back accesses; sampled in IDLE.
REQ-013 io_addr  output  24  address to IO-register file.
REQ-014 io_data_in  output  32  write data to IO-register file.
REQ-015 io_data_out  input  32  combinational read data from IO-register file.
REQ-016 io_read, io_write  output  1 each  access strobes.
REQ-017 io_width  output  2  access width.

Function
REQ-018 FSM states IDLE, ACC, ACK; one transaction = 3 cycles, max one per 3 cycles.
REQ-019 IDLE, no request: stay IDLE, io_read = io_write = 0.
REQ-020 IDLE, request(s) present: select winner, register its addr/wdata/width/write into io_* outputs, set io_write = write or io_read = !write, go ACC.
REQ-021 Winner priority: DMA over CPU, except when starve_cnt == STARVE_LIMIT, in which case CPU wins.
REQ-022 dma_lock high with dma_req high in IDLE: DMA wins regardless of starve_cnt.
REQ-023 starve_cnt (width clog2(STARVE_LIMIT+1)): increments on each DMA grant while cpu_req high; clears on CPU grant or when cpu_req low in IDLE; saturates at STARVE_LIMIT.
REQ-024 ACC: io_* outputs held stable for exactly this cycle (the IO-register write commits at the edge ending ACC); io_data_out captured into the winner's rdata register at that edge; go ACK.
REQ-025 ACK: winner's ack = 1 for exactly one cycle, io_read = io_write = 0; other ack = 0; go IDLE.
REQ-026 rdata on write transactions returns the pre-write register word as presented on io_data_out, unmodified.
REQ-027 cpu_rdata/dma_rdata hold last captured value until the next capture for that port.
REQ-028 Requester signals are sampled only in IDLE; changes during ACC/ACK are ignored.
REQ-029 Request held high past ack = new request, arbitrated at next IDLE.
REQ-030 cpu_ack and dma_ack never high in the same cycle; io_read and io_write never both high.

Reset
REQ-031 rst high: state = IDLE, io_read = io_write = 0, cpu_ack = dma_ack = 0, io_addr = io_data_in = 0, io_width = 0, cpu_rdata = dma_rdata = 0, starve_cnt = 0, immediately (no clock).
REQ-032 rst asserted during ACC: io_write drops asynchronously, no IO write commits, no ack issued; pending requester re-arbitrates after release.
REQ-033 First arbitration occurs at the first rising edge with rst low.

Verification
REQ-034 CPU read alone: cpu_req, addr 0x100, width 10 at edge 0 -> io_read high cycle 1 with io_addr 0x100; cpu_ack high cycle 2, cpu_rdata = io_data_out of cycle 1.
REQ-035 Simultaneous CPU and DMA requests -> DMA granted first (dma_ack cycle 2), CPU next (cpu_ack cycle 5).
REQ-036 DMA continuously requesting, CPU waiting, STARVE_LIMIT 4 -> 4 dma_acks, then cpu_ack; starve_cnt back to 0.
REQ-037 Same as 036 with dma_lock high -> CPU never granted while lock held; cpu_ack 3 cycles after lock drops if DMA still requests... CPU wins (starve_cnt saturated).
REQ-038 CPU write 0x00AB, width 00, addr 0x105 -> io_write high one cycle, io_data_in 0x000000AB, io_width 00, cpu_ack next cycle.
REQ-039 rst pulse during ACC of a write -> io_write low same cycle, no ack, target register unchanged; request re-served after release.
